mem_access_unit: RTL and testbench

- Initiator side of the data-memory port: accepts one load/store request at a time from the MEM stage.
- Translates the request into the word address, raw store data, read/write strobes and 4-bit byte-enable that the data memory consumes.
- Waits for memory completion, then returns sign- or zero-extended load data, or an exception, as a one-cycle response.
- Sits between the MEM pipeline stage and the 4K-word data memory.

---
 rtl/mem_access_unit_pkg.sv | 56 +++++
 rtl/mem_access_unit_load_extend.sv | 28 ++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: opcodes, response
// codes, FSM encoding and the alignment/byte-enable helpers.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        EXC_OK         = 2'd0,
        EXC_LOAD_ADDR  = 2'd1,
        EXC_STORE_ADDR = 2'd2,
        EXC_TIMEOUT    = 2'd3
    } resp_exc_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic is_store(input mem_op_e op);
        logic st;
        st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        return st;
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            OP_LW, OP_SW:         bad = (addr_lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = addr_lo[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Little-endian lane enables; every load reads the full word.
    function automatic logic [3:0] access_be(input mem_op_e op, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (op)
            OP_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   be = 4'b0001 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Lane select plus sign/zero extension of a loaded word; purely combinational
// so the writeback stage can reuse it.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        case (op)
            OP_LW:   data = word;
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h000000, byte_sel};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: one load/store at a time from MEM,
// with alignment/range checking, a bounded wait for mem_ready and a one-cycle response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_pc,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_exc
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d;
    mem_op_e           op_q, op_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       mem_pc_q, mem_pc_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    resp_exc_e         resp_exc_q, resp_exc_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    mem_op_e           req_op_e;
    logic              addr_err;
    logic [CNT_W-1:0]  wait_inc;
    logic              timeout;
    logic [31:0]       load_data;

    assign req_op_e = mem_op_e'(req_op);
    assign addr_err = is_misaligned(req_op_e, req_addr[1:0]) || (|req_addr[31:ADDR_W+2]);
    assign wait_inc = wait_cnt_q + CNT_W'(1);
    assign timeout  = !mem_ready && (wait_inc == CNT_W'(WAIT_MAX));

    load_extend u_load_extend (
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .word    (mem_rdata),
        .data    (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LW;
            addr_lo_q    <= 2'b00;
            mem_a_q      <= '0;
            mem_wdata_q  <= 32'h0000_0000;
            mem_pc_q     <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_exc_q   <= EXC_OK;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_lo_q    <= addr_lo_d;
            mem_a_q      <= mem_a_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_pc_q     <= mem_pc_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = addr_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (mem_ready || timeout) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the transition being taken, so strobes are
    // high exactly during ACCESS and the response flops update only on entry to RESP.
    always_comb begin
        op_d         = op_q;
        addr_lo_d    = addr_lo_q;
        mem_a_d      = mem_a_q;
        mem_wdata_d  = mem_wdata_q;
        mem_pc_d     = mem_pc_q;
        resp_rdata_d = resp_rdata_q;
        resp_exc_d   = resp_exc_q;
        wait_cnt_d   = wait_cnt_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_be_d     = 4'b0000;
        resp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op_e;
                    addr_lo_d   = req_addr[1:0];
                    mem_a_d     = req_addr[ADDR_W+1:2];
                    mem_wdata_d = req_wdata;
                    mem_pc_d    = req_pc;
                    wait_cnt_d  = '0;
                    if (addr_err) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                        resp_exc_d   = is_store(req_op_e) ? EXC_STORE_ADDR : EXC_LOAD_ADDR;
                    end else begin
                        mem_read_d  = !is_store(req_op_e);
                        mem_write_d = is_store(req_op_e);
                        mem_be_d    = access_be(req_op_e, req_addr[1:0]);
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    resp_valid_d = 1'b1;
                    resp_exc_d   = EXC_OK;
                    resp_rdata_d = is_store(op_q) ? 32'h0000_0000 : load_data;
                end else if (timeout) begin
                    resp_valid_d = 1'b1;
                    resp_exc_d   = EXC_TIMEOUT;
                    resp_rdata_d = 32'h0000_0000;
                    wait_cnt_d   = wait_inc;
                end else begin
                    wait_cnt_d  = wait_inc;
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                    mem_be_d    = mem_be_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_A      = mem_a_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_pc     = mem_pc_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_be     = mem_be_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_exc   = resp_exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected responses are queued when a
// request is driven and popped when resp_valid appears.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int ADDR_W   = 12;
    localparam int WAIT_MAX = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic [ADDR_W-1:0] mem_A;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_be;
    logic [31:0]       mem_pc;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_exc;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  exc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          resp_pulses = 0;
    int          exp_pulses = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    always @(negedge clk) if (resp_valid) resp_pulses++;

    mem_access_unit #(
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .mem_A      (mem_A),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_be     (mem_be),
        .mem_pc     (mem_pc),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request, then walks the access cycle by cycle: low_cycles is how
    // many ACCESS cycles see mem_ready=0 (-1 = never ready).
    task automatic applyStimulus(input string tag, input mem_op_e op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int low_cycles,
                                 input logic [31:0] exp_rdata, input logic [1:0] exp_exc);
        int          cyc;
        int          rd_cyc;
        int          wr_cyc;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          strobe_cycles;
        logic        done;
        logic        seen_strobe;
        logic        store;
        logic [3:0]  exp_be;
        logic [31:0] this_pc;
        exp_t        e;
        exp_t        got;

        store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        case (op)
            OP_SH:   exp_be = (addr[1] == 1'b0) ? 4'b0011 : 4'b1100;
            OP_SB:   case (addr[1:0])
                         2'd0:    exp_be = 4'b0001;
                         2'd1:    exp_be = 4'b0010;
                         2'd2:    exp_be = 4'b0100;
                         default: exp_be = 4'b1000;
                     endcase
            default: exp_be = 4'b1111;
        endcase
        if (exp_exc == 2'd1 || exp_exc == 2'd2) begin
            exp_lat       = 1;
            strobe_cycles = 0;
        end else if (exp_exc == 2'd3) begin
            exp_lat       = WAIT_MAX + 1;
            strobe_cycles = WAIT_MAX;
        end else begin
            exp_lat       = low_cycles + 2;
            strobe_cycles = low_cycles + 1;
        end
        exp_rd = store ? 0 : strobe_cycles;
        exp_wr = store ? strobe_cycles : 0;

        @(negedge clk);
        checkOutput({tag, "/req_ready"}, {31'd0, req_ready}, 32'd1);
        this_pc   = pc_ctr;
        pc_ctr    = pc_ctr + 32'd4;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = this_pc;
        e.rdata   = exp_rdata;
        e.exc     = exp_exc;
        sb_q.push_back(e);
        exp_pulses++;

        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_wdata = 32'h5555_5555;
        req_pc    = 32'hFFFF_FFFF;
        cyc = 1; rd_cyc = 0; wr_cyc = 0; done = 1'b0; seen_strobe = 1'b0;
        while (!done && cyc <= 40) begin
            if (resp_valid) begin
                done = 1'b1;
                checkOutput({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
                checkOutput({tag, "/strobes_in_resp"}, {26'd0, mem_read, mem_write, mem_be}, 32'd0);
                checkOutput({tag, "/sb_pending"}, 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    checkOutput({tag, "/resp_rdata"}, resp_rdata, got.rdata);
                    checkOutput({tag, "/resp_exc"}, {30'd0, resp_exc}, {30'd0, got.exc});
                end
            end else begin
                if (mem_read)  rd_cyc++;
                if (mem_write) wr_cyc++;
                if ((mem_read || mem_write) && !seen_strobe) begin
                    seen_strobe = 1'b1;
                    checkOutput({tag, "/mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
                    checkOutput({tag, "/mem_A"}, {20'd0, mem_A}, {20'd0, addr[13:2]});
                    checkOutput({tag, "/mem_pc"}, mem_pc, this_pc);
                    if (store) checkOutput({tag, "/mem_wdata"}, mem_wdata, wdata);
                end
                mem_ready = (low_cycles >= 0) && (cyc > low_cycles);
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({tag, "/resp_seen"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "/read_cycles"}, 32'(rd_cyc), 32'(exp_rd));
        checkOutput({tag, "/write_cycles"}, 32'(wr_cyc), 32'(exp_wr));
        mem_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_pc    = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset/outputs", {26'd0, mem_read, mem_write, mem_be}, 32'd0);
        checkOutput("reset/resp", {29'd0, resp_valid, resp_exc}, 32'd0);
        checkOutput("reset/mem_A", {20'd0, mem_A}, 32'd0);
        checkOutput("reset/resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset/mem_pc", mem_pc, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset/req_ready", {31'd0, req_ready}, 32'd1);
        $display("[TB] reset checks done");

        applyStimulus("sb_lane2", OP_SB, 32'h0000_0006, 32'h0000_00AB, 0, 32'h0, 2'd0);
        applyStimulus("sh_hi", OP_SH, 32'h0000_0012, 32'h0000_BEEF, 0, 32'h0, 2'd0);

        mem_rdata = 32'h8001_F0FE;
        applyStimulus("lb_0x8", OP_LB, 32'h0000_0008, 32'h0, 0, 32'hFFFF_FFFE, 2'd0);
        applyStimulus("lbu_0x9", OP_LBU, 32'h0000_0009, 32'h0, 0, 32'h0000_00F0, 2'd0);
        applyStimulus("lh_0xA", OP_LH, 32'h0000_000A, 32'h0, 0, 32'hFFFF_8001, 2'd0);
        applyStimulus("lhu_0xA", OP_LHU, 32'h0000_000A, 32'h0, 0, 32'h0000_8001, 2'd0);
        @(negedge clk);
        checkOutput("hold/resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("hold/resp_rdata", resp_rdata, 32'h0000_8001);
        applyStimulus("lw_top", OP_LW, 32'h0000_3FFC, 32'h0, 0, 32'h8001_F0FE, 2'd0);
        $display("[TB] load extension checks done");

        applyStimulus("sw_misalign", OP_SW, 32'h0000_0002, 32'h1111_2222, 0, 32'h0, 2'd2);
        applyStimulus("lh_misalign", OP_LH, 32'h0000_0001, 32'h0, 0, 32'h0, 2'd1);
        applyStimulus("lw_range", OP_LW, 32'h0000_4000, 32'h0, 0, 32'h0, 2'd1);

        mem_rdata = 32'h1234_5678;
        applyStimulus("lw_wait3", OP_LW, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 2'd0);
        applyStimulus("sh_timeout", OP_SH, 32'h0000_0030, 32'h0000_CAFE, -1, 32'h0, 2'd3);
        @(negedge clk);
        checkOutput("timeout/strobes_after", {26'd0, mem_read, mem_write, mem_be}, 32'd0);
        $display("[TB] error and wait checks done");

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'hA5A5_A5A5;
        req_pc    = pc_ctr;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        checkOutput("rst_mid/write_before", {31'd0, mem_write}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid/write_dropped", {31'd0, mem_write}, 32'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid/req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("rst_mid/no_extra_resp", 32'(resp_pulses), 32'(exp_pulses));
        checkOutput("end/sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
